// File: rtl/arb_req_mux.sv
// arb_req_mux: four per-port FWFT FIFOs feeding a registered output stream, popped by a one-hot arbiter grant.
// Optional ARB_REQ_MUX_GRANT_CHK_EN rejects illegal grants and raises a sticky o_err.
module arb_req_mux #(
  parameter int DW = 8,
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             areset,
  input  logic [4*DW-1:0]                  i_data,
  input  logic [3:0]                       i_valid,
  output logic [3:0]                       o_ready,
  output logic [3:0]                       o_req,
  input  logic [3:0]                       i_grant,
  output logic [DW-1:0]                    o_data,
  output logic [1:0]                       o_src,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [4*($clog2(DEPTH)+1)-1:0]   o_level
`ifdef ARB_REQ_MUX_GRANT_CHK_EN
  , output logic                           o_err
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [DW-1:0] mem [4][DEPTH];
  logic [AW-1:0] wptr [4];
  logic [AW-1:0] rptr [4];
  logic [LW-1:0] level [4];
  logic [3:0] push, pop;
  logic [1:0] sel;
  logic slot_free;
  always_comb begin
    slot_free = !o_valid || i_ready;
    o_ready = '0;
    o_req = '0;
    push = '0;
    o_level = '0;
    for (int p = 0; p < 4; p++) begin
      o_ready[p] = level[p] != LW'(DEPTH);
      o_req[p] = (level[p] != '0) && slot_free;
      push[p] = i_valid[p] && o_ready[p];
      o_level[p*LW +: LW] = level[p];
    end
  end
`ifdef ARB_REQ_MUX_GRANT_CHK_EN
  logic legal, illegal;
  always_comb begin
    legal = (i_grant != 4'd0) && ((i_grant & (i_grant - 4'd1)) == 4'd0) && ((i_grant & ~o_req) == 4'd0);
    illegal = (i_grant != 4'd0) && !legal;
    pop = legal ? i_grant : 4'd0;
  end
  always_ff @(posedge clk or posedge areset)
    if (areset) o_err <= 1'b0;
    else if (illegal) o_err <= 1'b1;
`else
  logic [3:0] hit;
  always_comb begin
    hit = i_grant & o_req;
    pop = hit & (~hit + 4'd1);
  end
`endif
  always_comb sel = pop[3] ? 2'd3 : pop[2] ? 2'd2 : pop[1] ? 2'd1 : 2'd0;
  always_ff @(posedge clk)
    for (int p = 0; p < 4; p++)
      if (push[p]) mem[p][wptr[p]] <= i_data[p*DW +: DW];
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      for (int p = 0; p < 4; p++) begin
        wptr[p] <= '0;
        rptr[p] <= '0;
        level[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (push[p]) wptr[p] <= wptr[p] + AW'(1);
        if (pop[p]) rptr[p] <= rptr[p] + AW'(1);
        level[p] <= level[p] + LW'(push[p]) - LW'(pop[p]);
      end
    end
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      o_valid <= 1'b0;
      o_data <= '0;
      o_src <= '0;
    end else if (pop != 4'd0) begin
      o_valid <= 1'b1;
      o_data <= mem[sel][rptr[sel]];
      o_src <= sel;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
endmodule

// File: tb/tb_arb_req_mux.sv
// tb_arb_req_mux: queue-based reference model with a per-cycle compare, a weighted round-robin arbiter (1,5,2,3), directed and random traffic.
module tb_arb_req_mux;
  logic clk = 1'b0;
  logic areset = 1'b1;
  logic [31:0] i_data = '0;
  logic [3:0] i_valid = '0;
  logic [3:0] o_ready, o_req, i_grant;
  logic [7:0] o_data;
  logic [1:0] o_src;
  logic o_valid;
  logic i_ready = 1'b0;
  logic [11:0] o_level;
`ifdef ARB_REQ_MUX_GRANT_CHK_EN
  logic o_err;
`endif
  arb_req_mux #(.DW(8), .DEPTH(4)) dut (
    .clk(clk), .areset(areset), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_req(o_req), .i_grant(i_grant), .o_data(o_data), .o_src(o_src), .o_valid(o_valid),
    .i_ready(i_ready), .o_level(o_level)
`ifdef ARB_REQ_MUX_GRANT_CHK_EN
    , .o_err(o_err)
`endif
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Weighted round-robin arbiter: a port keeps the grant until its weight is spent.
  int w [4] = '{1, 5, 2, 3};
  int cur = 0;
  int cnt = 0;
  logic [3:0] arb_g;
  logic a_found;
  logic use_force = 1'b0;
  logic [3:0] force_g = '0;
  always_comb begin
    arb_g = '0;
    a_found = 1'b0;
    if (o_req[cur] && cnt < w[cur]) arb_g[cur] = 1'b1;
    else
      for (int k = 1; k <= 4; k++)
        if (!a_found && o_req[(cur + k) % 4]) begin
          arb_g[(cur + k) % 4] = 1'b1;
          a_found = 1'b1;
        end
  end
  assign i_grant = use_force ? force_g : arb_g;
  always @(posedge clk or posedge areset)
    if (areset) begin
      cur <= 0;
      cnt <= 0;
    end else if (!use_force && arb_g != 4'd0) begin
      for (int k = 0; k < 4; k++)
        if (arb_g[k]) begin
          if (k == cur && cnt < w[cur]) cnt <= cnt + 1;
          else begin
            cur <= k;
            cnt <= 1;
          end
        end
    end
  logic [7:0] q [4][$];
  logic exp_valid = 1'b0;
  logic [7:0] exp_data = '0;
  logic [1:0] exp_src = '0;
  logic exp_err = 1'b0;
  always @(negedge clk) begin
    logic [3:0] e_ready, e_req, g, e_push;
    logic [11:0] e_level;
    int pi;
    if (areset) begin
      for (int p = 0; p < 4; p++) q[p].delete();
      exp_valid = 1'b0;
      exp_data = '0;
      exp_src = '0;
      exp_err = 1'b0;
    end
    for (int p = 0; p < 4; p++) begin
      e_ready[p] = q[p].size() != 4;
      e_req[p] = q[p].size() != 0 && (!exp_valid || i_ready);
      e_level[p*3 +: 3] = 3'(q[p].size());
      e_push[p] = i_valid[p] && e_ready[p];
    end
    chk("o_ready", 32'(o_ready), 32'(e_ready));
    chk("o_req", 32'(o_req), 32'(e_req));
    chk("o_level", 32'(o_level), 32'(e_level));
    chk("o_valid", 32'(o_valid), 32'(exp_valid));
    chk("o_data", 32'(o_data), 32'(exp_data));
    chk("o_src", 32'(o_src), 32'(exp_src));
`ifdef ARB_REQ_MUX_GRANT_CHK_EN
    chk("o_err", 32'(o_err), 32'(exp_err));
`endif
    if (!areset) begin
      g = i_grant;
      pi = -1;
`ifdef ARB_REQ_MUX_GRANT_CHK_EN
      if ($countones(g) == 1 && (g & ~e_req) == 4'd0) pi = $clog2(g);
      else if (g != 4'd0) exp_err = 1'b1;
`else
      for (int p = 3; p >= 0; p--) if (g[p] && e_req[p]) pi = p;
`endif
      if (pi >= 0) begin
        exp_data = q[pi].pop_front();
        exp_src = 2'(pi);
        exp_valid = 1'b1;
      end else if (i_ready) exp_valid = 1'b0;
      for (int p = 0; p < 4; p++) if (e_push[p]) q[p].push_back(i_data[p*8 +: 8]);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    areset = 1'b1;
    i_valid = '0;
    use_force = 1'b0;
    step();
    step();
    areset = 1'b0;
  endtask
  int sent [4];
  task automatic feed();
    logic [3:0] v, rdy;
    for (int p = 0; p < 4; p++) begin
      v[p] = sent[p] < 8;
      i_data[p*8 +: 8] = 8'(p * 16 + sent[p]);
    end
    i_valid = v;
    rdy = o_ready;
    step();
    for (int p = 0; p < 4; p++) if (v[p] && rdy[p]) sent[p]++;
  endtask
  task automatic preload();
    do_reset();
    sent = '{0, 0, 0, 0};
    i_ready = 1'b0;
    repeat (8) feed();
  endtask
  initial begin
    logic [1:0] srcs [12];
    logic [1:0] want [12];
    int nb, cyc, idle;
    want = '{0, 1, 1, 1, 1, 1, 2, 2, 3, 3, 3, 0};
    do_reset();
    repeat (3) begin
      step();
      chk("idle_ready", 32'(o_ready), 32'hF);
      chk("idle_req", 32'(o_req), 32'h0);
      chk("idle_valid", 32'(o_valid), 32'h0);
      chk("idle_level", 32'(o_level), 32'h0);
    end
    i_ready = 1'b1;
    i_valid = 4'b0100;
    i_data = 32'h0011_0000;
    step();
    chk("lat_valid0", 32'(o_valid), 32'h0);
    chk("lat_req", 32'(o_req), 32'h4);
    i_data = 32'h0022_0000;
    step();
    chk("sp_data0", {22'(0), o_src, o_data}, 32'h211);
    i_data = 32'h0033_0000;
    step();
    chk("sp_data1", {22'(0), o_src, o_data}, 32'h222);
    i_valid = '0;
    step();
    chk("sp_data2", {22'(0), o_src, o_data}, 32'h233);
    step();
    chk("sp_done", 32'(o_valid), 32'h0);
    do_reset();
    i_ready = 1'b0;
    i_valid = 4'b0001;
    i_data = 32'hA0;
    step();
    i_valid = '0;
    step();
    chk("full_first", {23'(0), o_valid, o_data}, 32'h1A0);
    i_valid = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      i_data = 32'(8'hA1 + k);
      step();
    end
    i_valid = '0;
    chk("full_level", 32'(o_level), 32'h004);
    chk("full_ready", 32'(o_ready), 32'hE);
    chk("full_req", 32'(o_req), 32'h0);
    i_ready = 1'b1;
    repeat (4) step();
    chk("full_last", 32'(o_data), 32'hA4);
    chk("full_drained", 32'(o_level), 32'h0);
    preload();
    chk("pre_level", 32'(o_level), 32'h924);
    chk("pre_out", {23'(0), o_valid, o_data}, 32'h100);
    i_ready = 1'b1;
    nb = 0;
    cyc = 0;
    idle = 0;
    while (nb < 32 && cyc < 200) begin
      if (o_valid) begin
        if (nb < 12) srcs[nb] = o_src;
        nb++;
      end else idle++;
      feed();
      cyc++;
    end
    chk("wrr_beats", 32'(nb), 32'd32);
    chk("wrr_cycles", 32'(cyc), 32'd32);
    chk("wrr_idle", 32'(idle), 32'd0);
    for (int k = 0; k < 12; k++) chk($sformatf("wrr_src%0d", k), 32'(srcs[k]), 32'(want[k]));
    preload();
    nb = 0;
    cyc = 0;
    while (nb < 32 && cyc < 300) begin
      i_ready = cyc[0];
      if (o_valid && i_ready) nb++;
      feed();
      cyc++;
    end
    chk("bp_beats", 32'(nb), 32'd32);
    do_reset();
    i_ready = 1'b1;
    use_force = 1'b1;
`ifdef ARB_REQ_MUX_GRANT_CHK_EN
    force_g = 4'b1000;
    step();
    chk("err_set", 32'(o_err), 32'h1);
    chk("err_novalid", 32'(o_valid), 32'h0);
    force_g = 4'b0000;
    i_valid = 4'b1001;
    i_data = 32'h3C00_0005;
    step();
    i_valid = '0;
    force_g = 4'b0011;
    step();
    chk("err_nopop", 32'(o_level), 32'h201);
    chk("err_hold", 32'(o_err), 32'h1);
    use_force = 1'b0;
    do_reset();
    chk("err_clear", 32'(o_err), 32'h0);
`else
    force_g = 4'b0001;
    i_valid = 4'b1000;
    i_data = 32'h3C00_0000;
    step();
    i_valid = '0;
    step();
    step();
    chk("ign_valid", 32'(o_valid), 32'h0);
    chk("ign_level", 32'(o_level), 32'h200);
    force_g = 4'b1001;
    step();
    chk("ign_pop", {22'(0), o_src, o_data}, 32'h33C);
    use_force = 1'b0;
`endif
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      i_valid = 4'($urandom);
      i_data = $urandom;
      i_ready = $urandom_range(0, 9) < 7;
      use_force = $urandom_range(0, 9) == 0;
      force_g = 4'($urandom);
      step();
    end
    use_force = 1'b0;
    i_valid = 4'hF;
    step();
    areset = 1'b1;
    #1;
    chk("async_valid", 32'(o_valid), 32'h0);
    chk("async_level", 32'(o_level), 32'h0);
    step();
    areset = 1'b0;
    i_valid = '0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
